// File: rtl/bus_rx_latch_pkg.sv
// Shared definitions for the bus receive latch and its transmit-side partner:
// FSM encoding, synchroniser depth default, and the odd-parity helper.
package bus_rx_latch_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;

    // Returns the parity bit that makes the total number of ones odd.
    // Callers zero-extend narrower words; zero bits do not change parity.
    function automatic logic odd_par(input logic [31:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/bus_rx_sync.sv
// N-stage synchroniser for an asynchronous active-low strobe, reset to idle (1),
// with a registered falling-edge pulse. An edge is only reported once a real
// high level has been seen after reset, so a strobe held low across reset is ignored.
module bus_rx_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic nstb_i,
    output logic nstb_o,
    output logic fall_o
);

    logic [N-1:0] sync_q;
    logic [N-1:0] vld_q;
    logic         prev_q;
    logic         armed_q;
    logic         fall_q;

    // vld_q marks when the last stage holds a real sample rather than the reset value.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q  <= '1;
            vld_q   <= '0;
            prev_q  <= 1'b1;
            armed_q <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], nstb_i};
            vld_q  <= {vld_q[N-2:0], 1'b1};
            prev_q <= sync_q[N-1];
            if (vld_q[N-1] && sync_q[N-1]) begin
                armed_q <= 1'b1;
            end
            fall_q <= armed_q & prev_q & ~sync_q[N-1];
        end
    end

    assign nstb_o = sync_q[N-1];
    assign fall_o = fall_q;

endmodule

// File: rtl/bus_rx_latch.sv
// Receive-side latch for a strobed tri-state bus segment: synchronises the strobe,
// holds one word for a valid/ack consumer, and reports busy and overrun.
// Optional parity checking is enabled with BUS_RX_PARITY_EN.
//
// state    | meaning
// ST_EMPTY | no word held, rd_valid=0
// ST_FULL  | word held for the consumer, rd_valid=1
module bus_rx_latch
    import bus_rx_latch_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] bus_data,
    input  logic             bus_nstb,
`ifdef BUS_RX_PARITY_EN
    input  logic             bus_par,
    output logic             perr,
`endif
    output logic             bus_nbusy,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ack,
    output logic             ovr,
    input  logic             ovr_clr
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             ovr_q;
    logic             nbusy_q;
    logic             strb_lvl;
    logic             strb_fall;
    logic             ack_s;
    logic             capture;
    logic             ovr_set;

    bus_rx_sync #(.N(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .nreset (nreset),
        .nstb_i (bus_nstb),
        .nstb_o (strb_lvl),
        .fall_o (strb_fall)
    );

    assign ack_s = rd_ack & (state_q == ST_FULL);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (strb_fall) state_d = ST_FULL;
            ST_FULL:  if (ack_s && !strb_fall) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // A new edge coinciding with ack replaces the word instead of overrunning.
    always_comb begin
        capture  = 1'b0;
        ovr_set  = 1'b0;
        rd_valid = 1'b0;
        case (state_q)
            ST_EMPTY: capture = strb_fall;
            ST_FULL: begin
                rd_valid = 1'b1;
                capture  = strb_fall & ack_s;
                ovr_set  = strb_fall & ~ack_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_data_q <= '0;
            ovr_q     <= 1'b0;
            nbusy_q   <= 1'b1;
        end else begin
            if (capture) begin
                rd_data_q <= bus_data;
            end
            if (ovr_set) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
            nbusy_q <= !((state_q == ST_FULL) || !strb_lvl);
        end
    end

`ifdef BUS_RX_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            perr_q <= 1'b0;
        end else if (capture) begin
            perr_q <= (bus_par != odd_par(32'(bus_data)));
        end else if (ack_s) begin
            perr_q <= 1'b0;
        end
    end

    assign perr = perr_q;
`endif

    assign rd_data   = rd_data_q;
    assign ovr       = ovr_q;
    assign bus_nbusy = nbusy_q;

endmodule
